// File: rtl/score_popup_engine.sv
// Floating score popups: each slot holds its label for one step, then rises and
// fades over NUM_STEPS steps before freeing itself for the next request.
module score_popup_engine #(
    parameter int         NUM_SLOTS        = 4,
    parameter int         FRAMES_PER_STEP  = 16,
    parameter int         NUM_STEPS        = 7,
    parameter logic [7:0] FADE_STEP        = 8'h04,
    parameter int         RISE_PER_STEP    = 1,
    parameter bit         OVERWRITE_OLDEST = 1'b0
) (
    input  logic                    frame_clk,
    input  logic                    reset,
    input  logic                    trig_valid,
    output logic                    trig_ready,
    input  logic [9:0]              trig_x,
    input  logic [9:0]              trig_y,
    input  logic [7:0]              trig_value,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [10*NUM_SLOTS-1:0] slot_x,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic [8*NUM_SLOTS-1:0]  slot_value,
    output logic [8*NUM_SLOTS-1:0]  slot_fade,
    output logic [7:0]              evict_cnt
);

    localparam int          IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
    localparam logic [3:0]  LAST_STEP  = 4'(NUM_STEPS);
    localparam logic [10:0] RISE_W     = 11'(RISE_PER_STEP);

    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [9:0]           x_q     [NUM_SLOTS];
    logic [9:0]           x_d     [NUM_SLOTS];
    logic [9:0]           y_q     [NUM_SLOTS];
    logic [9:0]           y_d     [NUM_SLOTS];
    logic [7:0]           value_q [NUM_SLOTS];
    logic [7:0]           value_d [NUM_SLOTS];
    logic [7:0]           fade_q  [NUM_SLOTS];
    logic [7:0]           fade_d  [NUM_SLOTS];
    logic [3:0]           step_q  [NUM_SLOTS];
    logic [3:0]           step_d  [NUM_SLOTS];
    logic [7:0]           cnt_q   [NUM_SLOTS];
    logic [7:0]           cnt_d   [NUM_SLOTS];
    logic [7:0]           evict_cnt_q, evict_cnt_d;

    logic             idle_found;
    logic [IDX_W-1:0] idle_idx;
    logic [IDX_W-1:0] evict_idx;
    logic [IDX_W-1:0] load_idx;
    logic [11:0]      best_key;
    logic             accept;
    logic             do_evict;

    // Allocation looks only at registered state, so a slot retiring on this
    // edge is still seen as busy and cannot be re-used until the next edge.
    always_comb begin : alloc
        idle_found = 1'b0;
        idle_idx   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!active_q[i] && !idle_found) begin
                idle_found = 1'b1;
                idle_idx   = IDX_W'(i);
            end
        end
        evict_idx = '0;
        best_key  = {step_q[0], cnt_q[0]};
        for (int i = 1; i < NUM_SLOTS; i++) begin
            if ({step_q[i], cnt_q[i]} > best_key) begin
                best_key  = {step_q[i], cnt_q[i]};
                evict_idx = IDX_W'(i);
            end
        end
    end

    assign trig_ready = OVERWRITE_OLDEST ? 1'b1 : ~&active_q;
    assign accept     = trig_valid && trig_ready;
    assign do_evict   = accept && !idle_found;
    assign load_idx   = idle_found ? idle_idx : evict_idx;

    always_comb begin : slot_next
        logic [10:0] y_dec;
        logic [8:0]  fade_inc;
        logic [8:0]  evict_inc;
        active_d = active_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            value_d[i] = value_q[i];
            fade_d[i]  = fade_q[i];
            step_d[i]  = step_q[i];
            cnt_d[i]   = cnt_q[i];
            y_dec      = {1'b0, y_q[i]} - RISE_W;
            fade_inc   = {1'b0, fade_q[i]} + {1'b0, FADE_STEP};
            if (active_q[i]) begin
                if (cnt_q[i] == LAST_FRAME) begin
                    cnt_d[i] = '0;
                    if (step_q[i] < LAST_STEP) begin
                        step_d[i] = step_q[i] + 4'd1;
                        y_d[i]    = y_dec[10] ? 10'd0 : y_dec[9:0];
                        fade_d[i] = fade_inc[8] ? 8'hFF : fade_inc[7:0];
                    end else begin
                        active_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
            // A fresh load (including an eviction) overrides any animation update.
            if (accept && (load_idx == IDX_W'(i))) begin
                active_d[i] = 1'b1;
                x_d[i]      = trig_x;
                y_d[i]      = trig_y;
                value_d[i]  = trig_value;
                fade_d[i]   = '0;
                step_d[i]   = '0;
                cnt_d[i]    = '0;
            end
        end
        evict_inc   = {1'b0, evict_cnt_q} + 9'd1;
        evict_cnt_d = evict_cnt_q;
        if (do_evict) begin
            evict_cnt_d = evict_inc[8] ? 8'hFF : evict_inc[7:0];
        end
    end

    always_ff @(posedge frame_clk) begin
        if (reset) begin
            active_q    <= '0;
            evict_cnt_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                value_q[i] <= '0;
                fade_q[i]  <= '0;
                step_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            active_q    <= active_d;
            evict_cnt_q <= evict_cnt_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                value_q[i] <= value_d[i];
                fade_q[i]  <= fade_d[i];
                step_q[i]  <= step_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
        assign slot_x[10*g +: 10]    = x_q[g];
        assign slot_y[10*g +: 10]    = y_q[g];
        assign slot_value[8*g +: 8]  = value_q[g];
        assign slot_fade[8*g +: 8]   = fade_q[g];
    end

    assign slot_active = active_q;
    assign evict_cnt   = evict_cnt_q;

endmodule

// File: doc/score_popup_engine.md
SCORE_POPUP_ENGINE -- requirements
Module: score_popup_engine

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of independent popups (1..8).
REQ-002 Parameter FRAMES_PER_STEP, default 16, frames per animation step (2..255).
REQ-003 Parameter NUM_STEPS, default 7, rise/fade steps after the hold step (1..15).
REQ-004 Parameter FADE_STEP, default 8'h04, fade increment per step.
REQ-005 Parameter RISE_PER_STEP, default 1, pixels moved up per step.
REQ-006 Parameter OVERWRITE_OLDEST, default 0; 0 = stall when full, 1 = evict the oldest slot when full.
REQ-007 frame_clk  in  1  frame-rate clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 trig_valid  in  1  new popup request.
REQ-010 trig_ready  out  1  request acceptable this cycle.
REQ-011 trig_x, trig_y  in  10 each  popup origin in screen pixels.
REQ-012 trig_value  in  8  points value shown by the renderer.
REQ-013 slot_active  out  NUM_SLOTS  per-slot busy flag.
REQ-014 slot_x, slot_y  out  10*NUM_SLOTS  current popup position; slot i occupies bits [10i+9:10i].
REQ-015 slot_value, slot_fade  out  8*NUM_SLOTS  latched value and current fade amount; renderer colour = 8'hFF - fade.
REQ-016 evict_cnt  out  8  number of evictions, saturating at 255.

Function
REQ-017 Each slot SHALL hold registered state: active, x, y, value, fade, step (4b), frame counter (8b).
REQ-018 trig_ready SHALL be 1 when OVERWRITE_OLDEST=1, else the OR of ~slot_active from registered state only.
REQ-019 On trig_valid && trig_ready, the lowest-index idle slot SHALL load x, y, value from trig_*, with fade=0, step=0, counter=0, active=1, visible on the following cycle.
REQ-020 At most one request SHALL be accepted per cycle; when trig_ready=0, the producer holds trig_valid and its data, and nothing is latched.
REQ-021 A slot going idle on an edge SHALL NOT be re-allocated on that same edge.
REQ-022 An active slot SHALL increment its counter every cycle; when counter == FRAMES_PER_STEP-1, a step boundary occurs and counter returns to 0.
REQ-023 Step 0 is the hold step: position and fade stay unchanged.
REQ-024 At a boundary with step < NUM_STEPS, the slot SHALL set step+1, y = y - RISE_PER_STEP saturating at 0, and fade = fade + FADE_STEP saturating at 8'hFF.
REQ-025 At a boundary with step == NUM_STEPS, the slot SHALL clear active and leave x, y, value, fade unchanged; total active time is (NUM_STEPS+1)*FRAMES_PER_STEP cycles.
REQ-026 When OVERWRITE_OLDEST=1 and all slots are active, an accepted request SHALL replace the slot with the largest {step,counter}, ties going to the lowest index, and SHALL increment evict_cnt (saturating).
REQ-027 An accepted request while any slot is idle SHALL NOT evict.
REQ-028 x SHALL never change after load; no arithmetic wraps; all internal sums are widened by 1 bit before saturation.
REQ-029 Slot outputs SHALL come directly from registers, with no combinational path from trig_* to slot_*.

Reset
REQ-030 While reset is high: all slot_active=0, slot_x/y/value/fade=0, step and counters=0, evict_cnt=0; trig_valid is ignored.
REQ-031 Reset asserted mid-animation SHALL clear all slots on that edge; the first request after reset deasserts goes to slot 0.
REQ-032 trig_ready SHALL be 1 on the first cycle after reset in both modes.

Verification
REQ-033 Defaults; one trigger (x=300, y=100, value=10) -> slot0 active for exactly 128 cycles; y=100 through cycle 16, then 99/fade 4; final y=93, fade 28; then idle.
REQ-034 Stall mode: 5 back-to-back triggers -> slots 0..3 filled, trig_ready=0, 5th held; accepted one cycle after slot0 frees, landing in slot0.
REQ-035 OVERWRITE_OLDEST=1: 4 triggers at cycles 0..3, 5th at cycle 10 -> slot0 replaced, evict_cnt=1, slots 1..3 untouched.
REQ-036 trig_y=3, RISE_PER_STEP=2, FADE_STEP=8'h50 -> y sequence 3,1,0,0..., fade saturates at 8'hFF with no wrap.
REQ-037 Reset pulse at cycle 50 of an animation -> all outputs zero next cycle; new trigger at cycle 52 -> slot0, fresh timing.
REQ-038 Slot0 expiring on the same edge a stall-mode trigger arrives with other slots full -> trigger not accepted that edge, accepted next edge into slot0.
